// File: rtl/audio_dsm.sv
// audio_dsm: gain-ramped first-order delta-sigma DAC
// for the APU mixer output, with click-free mute fades.
module audio_dsm #(
  parameter int WIDTH    = 6,
  parameter int RAMP_DIV = 1790
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data,
  input  logic             mute,
  output logic             dac,
  output logic             active,
  output logic             ramping
);

  typedef enum logic [1:0] {
    MUTED,
    RAMP_UP,
    PLAY,
    RAMP_DOWN
  } state_t;

  localparam int          PW   = WIDTH + 5;
  localparam logic [15:0] LAST = 16'(RAMP_DIV - 1);

  state_t           state;
  state_t           state_d;
  logic [4:0]       gain;
  logic [4:0]       gain_d;
  logic [15:0]      ramp_cnt;
  logic [15:0]      cnt_d;
  logic             tick;
  logic [WIDTH-1:0] sample_q;
  logic [WIDTH-1:0] level;
  logic [WIDTH:0]   acc;
  logic [PW-1:0]    prod;
  logic             prod_unused;

  assign tick = (ramp_cnt == LAST);

  // A reversal wins over a coincident tick and
  // restarts the step counter with gain untouched.
  always_comb begin
    state_d = state;
    gain_d  = gain;
    cnt_d   = '0;
    unique case (state)
      MUTED: begin
        gain_d = '0;
        if (!mute) state_d = RAMP_UP;
      end
      RAMP_UP: begin
        if (mute) begin
          state_d = RAMP_DOWN;
        end else if (tick) begin
          if (gain >= 5'd15) begin
            gain_d  = 5'd16;
            state_d = PLAY;
          end else begin
            gain_d = gain + 5'd1;
          end
        end else begin
          cnt_d = ramp_cnt + 16'd1;
        end
      end
      PLAY: begin
        gain_d = 5'd16;
        if (mute) state_d = RAMP_DOWN;
      end
      RAMP_DOWN: begin
        if (!mute) begin
          state_d = RAMP_UP;
        end else if (tick) begin
          if (gain <= 5'd1) begin
            gain_d  = '0;
            state_d = MUTED;
          end else begin
            gain_d = gain - 5'd1;
          end
        end else begin
          cnt_d = ramp_cnt + 16'd1;
        end
      end
      default: state_d = MUTED;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= MUTED;
      gain     <= '0;
      ramp_cnt <= '0;
    end else begin
      state    <= state_d;
      gain     <= gain_d;
      ramp_cnt <= cnt_d;
    end
  end

  // gain <= 16 keeps prod >> 4 within WIDTH bits
  assign prod        = PW'(sample_q) * PW'(gain);
  assign prod_unused = ^{prod[PW-1:WIDTH+4], prod[3:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_q <= '0;
      level    <= '0;
      acc      <= '0;
    end else begin
      sample_q <= data;
      level    <= prod[WIDTH+3:4];
      acc      <= {1'b0, acc[WIDTH-1:0]} + {1'b0, level};
    end
  end

  assign dac     = acc[WIDTH];
  assign active  = (state != MUTED);
  assign ramping = (state == RAMP_UP) || (state == RAMP_DOWN);

endmodule
